// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: add/sub mode encoding and the
// result record produced by the adder family.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int ALU_WIDTH = 32;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] sum;
        logic                 carryOut;
        logic                 overflow;
        logic                 zero;
    } alu_result_t;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational C-bit ripple slice; also exposes the carry into its top bit
// so the owner can form the two's-complement overflow flag.
module addsub_chunk #(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [C:0] carry;

    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = cin;
        for (int i = 0; i < C; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[C];
    assign c_msb = carry[C-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one C-bit chunk per stage with the carry registered
// between stages, valid/ready flow control with bubble collapse and flush.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);

    localparam int C = WIDTH / STAGES;

    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            rdy;
    logic [STAGES-1:0]            up_valid;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            c_d;
    logic [STAGES-1:0]            c_msb;
    logic [STAGES-1:0][WIDTH-1:0] res_q;
    logic [STAGES-1:0][WIDTH-1:0] res_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] b_d;
    logic                         ovf_q;
    logic                         ovf_d;
    logic                         zero_q;
    logic                         zero_d;
    logic [WIDTH-1:0]             b_prep;
    logic                         cin_prep;

    assign b_prep   = (sub == OP_ADD) ? operandB : ~operandB;
    assign cin_prep = (sub == OP_SUB) ? ~carryIn : carryIn;

    // Unconsumed operand bits travel right-shifted so the next chunk always
    // sits in the low C bits; results accumulate with zeros above the
    // newest chunk, which lets each stage simply OR its chunk in.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] r_src;
        logic             c_src;
        logic [C-1:0]     s_chunk;

        if (gi == 0) begin : g_first
            assign a_src        = operandA;
            assign b_src        = b_prep;
            assign c_src        = cin_prep;
            assign r_src        = '0;
            assign up_valid[gi] = in_valid && !flush;
        end else begin : g_next
            assign a_src        = a_q[gi-1];
            assign b_src        = b_q[gi-1];
            assign c_src        = c_q[gi-1];
            assign r_src        = res_q[gi-1];
            assign up_valid[gi] = v_q[gi-1];
        end

        addsub_chunk #(
            .C(C)
        ) u_chunk (
            .a    (a_src[C-1:0]),
            .b    (b_src[C-1:0]),
            .cin  (c_src),
            .s    (s_chunk),
            .cout (c_d[gi]),
            .c_msb(c_msb[gi])
        );

        assign a_d[gi]   = a_src >> C;
        assign b_d[gi]   = b_src >> C;
        assign res_d[gi] = r_src | (WIDTH'(s_chunk) << (gi * C));

        // A stage can move unless it and every stage downstream is full
        // while the consumer stalls.
        assign rdy[gi] = out_ready || !(&v_q[STAGES-1:gi]);
    end

    assign ovf_d    = c_msb[STAGES-1] ^ c_d[STAGES-1];
    assign zero_d   = (res_d[STAGES-1] == '0);
    assign in_ready = rdy[0] && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            c_q    <= '0;
            res_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k] && up_valid[k]) begin
                    res_q[k] <= res_d[k];
                    c_q[k]   <= c_d[k];
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                end
            end
            if (rdy[STAGES-1] && up_valid[STAGES-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
            if (flush) begin
                v_q <= '0;
            end else begin
                v_q <= (v_q & ~rdy) | (up_valid & rdy);
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign carryOut  = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], c_msb};

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomized checks of pipelined_addsub against an arithmetic
// reference model with an in-order expectation queue.
module tb_pipelined_addsub;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         carryIn = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carryOut;
    logic         overflow;
    logic         zero;

    logic         s_valid = 1'b0;
    logic [3:0]   s_a = '0;
    logic [3:0]   s_b = '0;
    logic         s_cin = 1'b0;
    logic         r1_in_ready, r1_out_valid, r1_co, r1_ov, r1_z;
    logic [3:0]   r1_sum;
    logic         r4_in_ready, r4_out_valid, r4_co, r4_ov, r4_z;
    logic [3:0]   r4_sum;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operandA(operandA), .operandB(operandB), .carryIn(carryIn), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carryOut(carryOut), .overflow(overflow), .zero(zero)
    );

    pipelined_addsub #(.WIDTH(4), .STAGES(1)) dut_w4s1 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(s_valid), .in_ready(r1_in_ready),
        .operandA(s_a), .operandB(s_b), .carryIn(s_cin), .sub(1'b0),
        .out_valid(r1_out_valid), .out_ready(1'b1),
        .sum(r1_sum), .carryOut(r1_co), .overflow(r1_ov), .zero(r1_z)
    );

    pipelined_addsub #(.WIDTH(4), .STAGES(4)) dut_w4s4 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(s_valid), .in_ready(r4_in_ready),
        .operandA(s_a), .operandB(s_b), .carryIn(s_cin), .sub(1'b0),
        .out_valid(r4_out_valid), .out_ready(1'b1),
        .sum(r4_sum), .carryOut(r4_co), .overflow(r4_ov), .zero(r4_z)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    bit           stall_prev = 1'b0;
    logic         acc = 1'b0;
    logic [W-1:0] st_a[8];
    logic [W-1:0] st_b[8];
    logic         st_ci[8];
    logic         st_sub[8];
    logic [3:0]   pat = 4'b1001;
    int           idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned for sum/carry, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        longint unsigned ua, ub, uc, full;
        longint          sa, sb, sc, sr;
        longint          smax, smin;
        exp_t            e;
        ua = a; ub = b; uc = ci ? 1 : 0;
        sa = $signed(a); sb = $signed(b); sc = ci ? 1 : 0;
        smax = 64'sd2147483647;
        smin = -smax - 1;
        if (!s) begin
            full  = ua + ub + uc;
            e.sum = full[W-1:0];
            e.co  = full[W];
            sr    = sa + sb + sc;
        end else begin
            full  = ua - ub - uc;
            e.sum = full[W-1:0];
            e.co  = (ua >= ub + uc);
            sr    = sa - sb - sc;
        end
        e.ov = (sr > smax) || (sr < smin);
        e.z  = (e.sum == '0);
        return e;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s, input logic ordy, input logic fl);
        exp_t e;
        @(negedge clk);
        in_valid = v; operandA = a; operandB = b; carryIn = ci; sub = s;
        out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!fl && !(q.size() == S && !ordy)));
        if (stall_prev) chk("hold_valid", 64'(out_valid), 64'(1));
        if (q.size() == 0) begin
            chk("idle_valid", 64'(out_valid), 64'(0));
        end else if (out_valid) begin
            e = q[0];
            chk("sum", 64'(sum), 64'(e.sum));
            chk("carryOut", 64'(carryOut), 64'(e.co));
            chk("overflow", 64'(overflow), 64'(e.ov));
            chk("zero", 64'(zero), 64'(e.z));
        end
        acc = v && in_ready;
        if (fl) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (out_valid && ordy && q.size() != 0) begin
                $display("xact out sum=%h co=%b ov=%b z=%b", sum, carryOut, overflow, zero);
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(a, b, ci, s));
            stall_prev = out_valid && !ordy;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s, input logic [W-1:0] es,
                          input logic eco, input logic eov, input logic ez);
        int lat;
        bit got;
        step(1'b1, a, b, ci, s, 1'b1, 1'b0);
        chk({name, ".accept"}, 64'(acc), 64'(1));
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            lat++;
            if (out_valid) begin
                got = 1'b1;
                chk({name, ".sum"}, 64'(sum), 64'(es));
                chk({name, ".carryOut"}, 64'(carryOut), 64'(eco));
                chk({name, ".overflow"}, 64'(overflow), 64'(eov));
                chk({name, ".zero"}, 64'(zero), 64'(ez));
            end
        end
        chk({name, ".latency"}, 64'(lat), 64'(S));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({name, ".drained"}, 64'(q.size()), 64'(0));
    endtask

    task automatic small_op(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic ci, input logic [3:0] es, input logic eco);
        int l1, l4;
        l1 = 0;
        l4 = 0;
        @(negedge clk);
        s_valid = 1'b1; s_a = a; s_b = b; s_cin = ci;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            if (r1_out_valid && l1 == 0) begin
                l1 = i;
                chk({name, ".s1.sum"}, 64'(r1_sum), 64'(es));
                chk({name, ".s1.carryOut"}, 64'(r1_co), 64'(eco));
            end
            if (r4_out_valid && l4 == 0) begin
                l4 = i;
                chk({name, ".s4.sum"}, 64'(r4_sum), 64'(es));
                chk({name, ".s4.carryOut"}, 64'(r4_co), 64'(eco));
            end
        end
        chk({name, ".s1.latency"}, 64'(l1), 64'(1));
        chk({name, ".s4.latency"}, 64'(l4), 64'(4));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.sum", 64'(sum), 64'(0));
        chk("reset.carryOut", 64'(carryOut), 64'(0));
        chk("reset.overflow", 64'(overflow), 64'(0));
        chk("reset.zero", 64'(zero), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op("add3_5", 32'h3, 32'h5, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
        run_op("max_pos_p1", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        run_op("sub5_3", 32'h5, 32'h3, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        run_op("sub3_5", 32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("min_neg_m1", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with the consumer stalling two cycles in four.
        for (int i = 0; i < 8; i++) begin
            st_a[i] = $urandom; st_b[i] = $urandom;
            st_ci[i] = 1'($urandom_range(0, 1)); st_sub[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int cyc = 0; cyc < 100 && (idx < 8 || q.size() != 0); cyc++) begin
            step(idx < 8, st_a[idx % 8], st_b[idx % 8], st_ci[idx % 8], st_sub[idx % 8],
                 pat[cyc % 4], 1'b0);
            if (acc) idx++;
        end
        chk("stream.accepted", 64'(idx), 64'(8));
        drain("stream");

        // Reset with three ops in flight, the oldest already presented.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'(0));
        chk("midrst.sum", 64'(sum), 64'(0));
        chk("midrst.carryOut", 64'(carryOut), 64'(0));
        chk("midrst.overflow", 64'(overflow), 64'(0));
        chk("midrst.zero", 64'(zero), 64'(0));
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush with two ops in flight and a third presented.
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h1234, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush.not_accepted", 64'(acc), 64'(0));
        repeat (6) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        drain("random");

        small_op("n15", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        small_op("n12", 4'b1100, 4'b1010, 1'b1, 4'b0111, 1'b1);
        small_op("n3", 4'b0011, 4'b0101, 1'b1, 4'b1001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; the next generation of the core adder used by the ALU and address-generation paths.
- Splits the operand into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- Adds subtract mode, signed-overflow and zero flags, a valid/ready handshake with per-stage bubble collapse, and a synchronous flush.

Parameters:
- WIDTH, 32: operand/result width in bits; must be divisible by STAGES.
- STAGES, 4: pipeline depth and chunk count; chunk width C = WIDTH/STAGES; STAGES=1 is a single-register adder.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all in-flight operations.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- operandA  in  WIDTH  first operand.
- operandB  in  WIDTH  second operand.
- carryIn  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+carryIn; 1 = A-B-carryIn.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carryOut  out  1  raw carry out of bit WIDTH-1; in sub mode 1 = no borrow.
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset: all stage valid bits, data registers and outputs are cleared; out_valid=0, sum=0, carryOut=0, overflow=0, zero=0. Reset mid-operation discards every in-flight op, and no stale result ever appears afterwards.
- Operand prep at accept: B' = sub ? ~operandB : operandB; cin' = sub ? ~carryIn : carryIn.
- Stage k (0..STAGES-1) holds: valid v[k]; result chunks 0..k; registered carry out of chunk k; the unconsumed upper chunks of A and B'.
- Stage k computes chunk k as A_k + B'_k + carry_{k-1}, where stage 0 uses cin'.
- The last stage also registers carryOut, overflow (carry into MSB XOR carry out of MSB) and zero. The output ports are the last-stage registers.
- Handshake:
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0]; this is combinational from out_ready.
  - A transfer occurs when valid && ready on the same edge.
  - A stage with rdy=0 holds its contents unchanged.
  - A stage whose upstream is empty while it advances loads v=0, so bubbles collapse.
- Latency: an op accepted at edge t produces out_valid=1 after edge t+STAGES-1 (visible from cycle t+STAGES) when unstalled. Throughput is 1 op/cycle.
- out_valid and the result fields are stable while out_valid && !out_ready.
- Flush: clears all v[k] on the next edge. An op presented in the same cycle as flush is not accepted, and in_ready is forced to 0 while flush=1. Flush takes priority over every transfer.
- The in-order property holds: results leave in acceptance order, and none is dropped or duplicated.
- Wrap-around: 0xFFFFFFFF + 1 gives sum=0, carryOut=1, zero=1, overflow=0.
- Only v[] and the last-stage flag registers need a reset; data registers may be reset, but their contents are don't-care while invalid.

Decomposition:
- Shared package alu_pkg:
  - mode constants OP_ADD=1'b0 and OP_SUB=1'b1.
  - a result-struct typedef {sum, carryOut, overflow, zero}, reusable by the ALU.
- Sub-module addsub_chunk: combinational C-bit ripple slice (inputs a, b, cin; outputs s, cout, plus carry into its top bit for overflow). Instantiated STAGES times inside a generate loop; the pipeline registers live in pipelined_addsub.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: A=0x00000003, B=0x00000005, add, carryIn=0 -> after 4 cycles sum=0x00000008, carryOut=0, overflow=0, zero=0.
- Wrap and flags: 0x7FFFFFFF+1 -> sum=0x80000000, overflow=1, carryOut=0; 0xFFFFFFFF+0x00000001 -> sum=0, carryOut=1, zero=1.
- Subtract: 5-3 (sub=1, carryIn=0) -> sum=2, carryOut=1; 3-5 -> sum=0xFFFFFFFE, carryOut=0; 0x80000000-1 -> overflow=1.
- Back-to-back stream of 8 ops with out_ready toggled 1,0,0,1,... -> all 8 results in order, values held during stall, in_ready=0 only when the pipe is full and stalled.
- Reset asserted while 3 ops are in flight -> outputs 0 immediately; after deassert no output until a new op is accepted. flush=1 with 2 ops in flight and in_valid=1 -> none emerge and the presented op is not accepted.
- WIDTH=4, STAGES=1 and WIDTH=4, STAGES=4: 1111+1111+cin=1 -> sum=1111, carryOut=1; 1100+1010+1 -> sum=0111, carryOut=1; 0011+0101+1 -> sum=1001, carryOut=0.
